// File: rtl/motion_sequencer.sv
// Purpose : sequences the left/right stepper coil patterns for one motion command at a time.
// Latency : k-th step at k*DIV cycles after acceptance; done pulse SETTLE_CYC cycles after the last step.
// Backpress: cmd_ready only in IDLE with abort low; offers while busy are dropped, never queued.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake (cmd_ready is combinational from state and abort)
//   cmd_op            00 forward, 01 turn left, 10 turn right, 11 reverse
//   cmd_steps         step count for forward/reverse (turns use TURN_STEPS)
//   cmd_speed         0 -> DIV_SLOW cycles per step, 1 -> DIV_FAST
//   abort             cancels an active command without a done pulse
//   motor_left/right  coil patterns, held in every state, 0001 out of reset
//   busy, done        command in progress / one-cycle completion pulse
//
// Build option: define MOTION_HALF_STEP_EN for the 8-phase half-step sequence
// (3-bit phase index); otherwise the 4-phase full-step wave (2-bit index).
module motion_sequencer #(
  parameter int STEP_W     = 12,
  parameter int TURN_STEPS = 256,
  parameter int DIV_SLOW   = 50000,
  parameter int DIV_FAST   = 25000,
  parameter int SETTLE_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_speed,
  input  logic              abort,
  output logic [3:0]        motor_left,
  output logic [3:0]        motor_right,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] OP_FWD = 2'b00;
  localparam logic [1:0] OP_TL  = 2'b01;
  localparam logic [1:0] OP_TR  = 2'b10;
  localparam logic [1:0] OP_REV = 2'b11;

`ifdef MOTION_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  // Divider must hold 0..DIV-1 for the larger of the two rates.
  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              speed_q, speed_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [PH_W-1:0]   lidx_q, lidx_d;
  logic [PH_W-1:0]   ridx_q, ridx_d;
  logic              done_q, done_d;

  logic [DIV_W-1:0]  div_last;
  logic              left_dn;
  logic              right_dn;
  logic              accept;

  // Coil pattern for a phase index.
  function automatic logic [3:0] phase_pat(input logic [PH_W-1:0] idx);
    logic [3:0] p;
`ifdef MOTION_HALF_STEP_EN
    case (idx)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    p = 4'b0001;
      2'd1:    p = 4'b0010;
      2'd2:    p = 4'b0100;
      default: p = 4'b1000;
    endcase
`endif
    return p;
  endfunction

  // Terminal divider value for the latched speed.
  assign div_last = speed_q ? DIV_W'(DIV_FAST - 1) : DIV_W'(DIV_SLOW - 1);

  // Right wheel is mounted mirrored: its "forward" is a decrementing index.
  always_comb begin
    left_dn  = 1'b0;
    right_dn = 1'b0;
    case (op_q)
      OP_FWD:  begin left_dn = 1'b0; right_dn = 1'b1; end
      OP_TL:   begin left_dn = 1'b1; right_dn = 1'b1; end
      OP_TR:   begin left_dn = 1'b0; right_dn = 1'b0; end
      default: begin left_dn = 1'b1; right_dn = 1'b0; end // OP_REV
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) & ~abort;
  assign accept    = cmd_valid & cmd_ready;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    speed_d    = speed_q;
    step_cnt_d = step_cnt_q;
    div_d      = div_q;
    set_d      = set_q;
    lidx_d     = lidx_q;
    ridx_d     = ridx_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          speed_d = cmd_speed;
          if ((cmd_op == OP_TL) || (cmd_op == OP_TR)) begin
            step_cnt_d = STEP_W'(TURN_STEPS);
          end else begin
            step_cnt_d = cmd_steps;
          end
          div_d   = '0;
          set_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Abort wins over a coincident step: coils keep the current pattern.
          state_d = S_IDLE;
        end else if (step_cnt_q == '0) begin
          // Only reachable by a zero-step command: finish without settling.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (div_q == div_last) begin
          div_d      = '0;
          step_cnt_d = step_cnt_q - STEP_W'(1);
          lidx_d     = left_dn  ? (lidx_q - PH_W'(1)) : (lidx_q + PH_W'(1));
          ridx_d     = right_dn ? (ridx_q - PH_W'(1)) : (ridx_q + PH_W'(1));
          if (step_cnt_q == STEP_W'(1)) begin
            state_d = S_SETTLE;
            set_d   = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_FWD;
      speed_q    <= 1'b0;
      step_cnt_q <= '0;
      div_q      <= '0;
      set_q      <= '0;
      lidx_q     <= '0;
      ridx_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      speed_q    <= speed_d;
      step_cnt_q <= step_cnt_d;
      div_q      <= div_d;
      set_q      <= set_d;
      lidx_q     <= lidx_d;
      ridx_q     <= ridx_d;
      done_q     <= done_d;
    end
  end

  assign motor_left  = phase_pat(lidx_q);
  assign motor_right = phase_pat(ridx_q);
  assign busy        = (state_q == S_RUN) || (state_q == S_SETTLE);
  assign done        = done_q;

endmodule
